// File: rtl/orbit_euler_array.sv
// orbit_euler_array
//   Multi-channel fixed-point orbit integrator. Holds {x, y, vx, vy} for NCH
//   independent satellites and advances them all by nsteps Euler steps under a
//   central linear restoring force a = -k*r. Explicit or semi-implicit Euler is
//   chosen per run. One shared datapath is time-multiplexed: each channel takes
//   an ACC cycle (acceleration) followed by an UPD cycle (state write-back), and
//   every UPD produces one registered output strobe.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   start, nsteps, mode, k   : run request (accepted only in IDLE) and its
//                              latched parameters (mode 0 explicit, 1 semi-implicit)
//   ld_valid, ld_ch, ld_*    : initial-state write for one channel (IDLE only)
//   busy                     : run in progress
//   out_valid, out_ch,       : one-cycle strobe with the updated position of a
//   out_x, out_y               channel; values hold between strobes
//   step_count               : completed steps in the current or last run
//   done                     : one-cycle pulse at the end of a run
module orbit_euler_array #(
  parameter int W        = 32,
  parameter int F        = 16,
  parameter int NCH      = 4,
  parameter int DT_SHIFT = 4,
  parameter int CW       = 16,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [CW-1:0]  nsteps,
  input  logic           mode,
  input  logic [W-1:0]   k,
  input  logic           ld_valid,
  input  logic [CHW-1:0] ld_ch,
  input  logic [W-1:0]   ld_x,
  input  logic [W-1:0]   ld_y,
  input  logic [W-1:0]   ld_vx,
  input  logic [W-1:0]   ld_vy,
  output logic           busy,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [W-1:0]   out_x,
  output logic [W-1:0]   out_y,
  output logic [CW-1:0]  step_count,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_UPD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  // Clamp a 2W-bit signed value into W bits: it fits only when the top W+1
  // bits are all copies of the sign.
  function automatic logic signed [W-1:0] sat_wide(input logic signed [2*W-1:0] v);
    if ((&v[2*W-1:W-1]) || (~|v[2*W-1:W-1])) begin
      return v[W-1:0];
    end else if (v[2*W-1]) begin
      return MIN_VAL;
    end else begin
      return MAX_VAL;
    end
  endfunction

  // Saturating W-bit add using one guard bit.
  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) begin
      return s[W] ? MIN_VAL : MAX_VAL;
    end
    return s[W-1:0];
  endfunction

  // a = sat(-((k*r) >>> F)). The shifted product is at most 2^(2W-2-F) in
  // magnitude, so negating it in 2W bits cannot overflow.
  function automatic logic signed [W-1:0] accel(input logic signed [W-1:0] kv,
                                                input logic signed [W-1:0] r);
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] scaled;
    prod   = kv * r;
    scaled = -(prod >>> F);
    return sat_wide(scaled);
  endfunction

  state_t state_reg, state_next;
  logic             done_c;

  logic [CHW-1:0]   c_reg;
  logic [CW-1:0]    step_reg;
  logic [CW-1:0]    nsteps_reg;
  logic             mode_reg;
  logic signed [W-1:0] k_reg;
  logic             busy_reg;
  logic             out_valid_reg;
  logic [CHW-1:0]   out_ch_reg;
  logic [W-1:0]     out_x_reg, out_y_reg;
  logic signed [W-1:0] ax_reg, ay_reg;

  logic signed [W-1:0] x_mem  [NCH];
  logic signed [W-1:0] y_mem  [NCH];
  logic signed [W-1:0] vx_mem [NCH];
  logic signed [W-1:0] vy_mem [NCH];

  logic ld_ok;
  logic last_ch;
  logic last_step;

  assign ld_ok     = (state_reg == S_IDLE) && ld_valid;
  assign last_ch   = (c_reg == CHW'(NCH - 1));
  assign last_step = ((step_reg + CW'(1)) == nsteps_reg);

  // Shared datapath: read the current channel, compute acceleration (used in
  // ACC) and the new state from the registered acceleration (used in UPD).
  logic signed [W-1:0] cur_x, cur_y, cur_vx, cur_vy;
  logic signed [W-1:0] acc_x, acc_y;
  logic signed [W-1:0] vx_new, vy_new, vx_src, vy_src, x_new, y_new;

  assign cur_x  = x_mem[c_reg];
  assign cur_y  = y_mem[c_reg];
  assign cur_vx = vx_mem[c_reg];
  assign cur_vy = vy_mem[c_reg];

  assign acc_x  = accel(k_reg, cur_x);
  assign acc_y  = accel(k_reg, cur_y);

  assign vx_new = sat_add(cur_vx, ax_reg >>> DT_SHIFT);
  assign vy_new = sat_add(cur_vy, ay_reg >>> DT_SHIFT);
  // Semi-implicit advances position with the freshly updated velocity.
  assign vx_src = mode_reg ? vx_new : cur_vx;
  assign vy_src = mode_reg ? vy_new : cur_vy;
  assign x_new  = sat_add(cur_x, vx_src >>> DT_SHIFT);
  assign y_new  = sat_add(cur_y, vy_src >>> DT_SHIFT);

  // Per-channel state banks. Registers rather than RAM because reset must
  // clear every word.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic signed [W-1:0] x_q, y_q, vx_q, vy_q;
    logic ld_we, upd_we;

    assign ld_we  = ld_ok && (ld_ch == CHW'(gi));
    assign upd_we = (state_reg == S_UPD) && (c_reg == CHW'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        x_q  <= '0;
        y_q  <= '0;
        vx_q <= '0;
        vy_q <= '0;
      end else if (ld_we) begin
        x_q  <= ld_x;
        y_q  <= ld_y;
        vx_q <= ld_vx;
        vy_q <= ld_vy;
      end else if (upd_we) begin
        x_q  <= x_new;
        y_q  <= y_new;
        vx_q <= vx_new;
        vy_q <= vy_new;
      end
    end

    assign x_mem[gi]  = x_q;
    assign y_mem[gi]  = y_q;
    assign vx_mem[gi] = vx_q;
    assign vy_mem[gi] = vy_q;
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    done_c     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (nsteps == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: state_next = S_UPD;
      S_UPD: begin
        if (last_ch && last_step) begin
          state_next = S_DONE;
        end else begin
          state_next = S_ACC;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        done_c     = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg         <= '0;
      step_reg      <= '0;
      nsteps_reg    <= '0;
      mode_reg      <= 1'b0;
      k_reg         <= '0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_x_reg     <= '0;
      out_y_reg     <= '0;
      ax_reg        <= '0;
      ay_reg        <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            nsteps_reg <= nsteps;
            mode_reg   <= mode;
            k_reg      <= k;
            step_reg   <= '0;
            c_reg      <= '0;
            // A zero-step run only pulses done; it never looks busy.
            busy_reg   <= (nsteps != '0);
          end
        end
        S_ACC: begin
          ax_reg <= acc_x;
          ay_reg <= acc_y;
        end
        S_UPD: begin
          out_valid_reg <= 1'b1;
          out_ch_reg    <= c_reg;
          out_x_reg     <= x_new;
          out_y_reg     <= y_new;
          if (last_ch) begin
            c_reg    <= '0;
            step_reg <= step_reg + CW'(1);
          end else begin
            c_reg <= c_reg + CHW'(1);
          end
        end
        S_DONE: begin
          busy_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy       = busy_reg;
  assign out_valid  = out_valid_reg;
  assign out_ch     = out_ch_reg;
  assign out_x      = out_x_reg;
  assign out_y      = out_y_reg;
  assign step_count = step_reg;
  assign done       = done_c;

endmodule

// File: tb/tb_orbit_euler_array.sv
// tb_orbit_euler_array
//   Self-checking bench for orbit_euler_array: a table of directed vectors,
//   hand-written reset / ignored-request / zero-step sequences, and randomized
//   runs compared against a plain-arithmetic reference model of the orbits.
module tb_orbit_euler_array;
  localparam int W   = 32;
  localparam int F   = 16;
  localparam int NCH = 4;
  localparam int DT  = 4;
  localparam int CW  = 16;
  localparam int CHW = 2;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic           clk = 1'b0;
  logic           rst, start, mode, ld_valid;
  logic [CW-1:0]  nsteps;
  logic [W-1:0]   k, ld_x, ld_y, ld_vx, ld_vy;
  logic [CHW-1:0] ld_ch;
  logic           busy, out_valid, done;
  logic [CHW-1:0] out_ch;
  logic [W-1:0]   out_x, out_y;
  logic [CW-1:0]  step_count;

  orbit_euler_array #(.W(W), .F(F), .NCH(NCH), .DT_SHIFT(DT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .nsteps(nsteps), .mode(mode), .k(k),
    .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_x(ld_x), .ld_y(ld_y),
    .ld_vx(ld_vx), .ld_vy(ld_vy), .busy(busy), .out_valid(out_valid),
    .out_ch(out_ch), .out_x(out_x), .out_y(out_y), .step_count(step_count),
    .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: true integers, clamped after every operation.
  longint mx[NCH], my[NCH], mvx[NCH], mvy[NCH];

  typedef struct {
    int     ch;
    longint x;
    longint y;
  } out_t;
  out_t expq[$];

  logic [W-1:0] last_x[NCH];
  logic [W-1:0] last_y[NCH];

  typedef struct {
    bit          do_load;
    int          ch;
    logic [31:0] x, y, vx, vy, kk;
    bit          md;
    logic [31:0] ex, ey;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint accel(input longint kk, input longint r);
    return sat(-((kk * r) >>> F));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
    end
  endtask

  // Advance every orbit n steps; outputs appear channel by channel per step.
  task automatic model_run(input int n, input bit md, input longint kk);
    longint ax, ay, nx, ny, nvx, nvy;
    out_t o;
    for (int s = 0; s < n; s++) begin
      for (int j = 0; j < NCH; j++) begin
        ax = accel(kk, mx[j]);
        ay = accel(kk, my[j]);
        nvx = sat(mvx[j] + (ax >>> DT));
        nvy = sat(mvy[j] + (ay >>> DT));
        if (md) begin
          nx = sat(mx[j] + (nvx >>> DT));
          ny = sat(my[j] + (nvy >>> DT));
        end else begin
          nx = sat(mx[j] + (mvx[j] >>> DT));
          ny = sat(my[j] + (mvy[j] >>> DT));
        end
        mx[j] = nx; my[j] = ny; mvx[j] = nvx; mvy[j] = nvy;
        o.ch = j; o.x = nx; o.y = ny;
        expq.push_back(o);
      end
    end
  endtask

  task automatic load(input int ch, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] vx, input logic [W-1:0] vy);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_ch = ch[CHW-1:0];
    ld_x = x; ld_y = y; ld_vx = vx; ld_vy = vy;
    @(negedge clk);
    ld_valid = 1'b0;
    mx[ch]  = longint'($signed(x));
    my[ch]  = longint'($signed(y));
    mvx[ch] = longint'($signed(vx));
    mvy[ch] = longint'($signed(vy));
  endtask

  // One run: start at edge t, then check every cycle t+1 .. last+2 for the
  // strobe cadence, busy window, done pulse and streamed positions. With poke
  // set, a stray start and load are issued mid-run and must be ignored.
  task automatic run(input int n, input bit md, input logic [W-1:0] kk, input bit poke);
    int   last;
    int   nout;
    out_t e;
    for (int i = 0; i < NCH; i++) begin
      last_x[i] = 'x; last_y[i] = 'x;
    end
    model_run(n, md, longint'($signed(kk)));
    @(negedge clk);
    start = 1'b1; nsteps = n[CW-1:0]; mode = md; k = kk;
    @(negedge clk);
    start = 1'b0;
    last = (n == 0) ? 1 : 1 + 2 * NCH * n;
    nout = 0;
    for (int rel = 1; rel <= last + 2; rel++) begin
      chk("busy", busy, (n > 0 && rel <= last));
      chk("out_valid", out_valid, (n > 0 && rel >= 3 && rel <= last && (rel % 2) == 1));
      chk("done", done, (rel == last));
      if (rel == 1 || rel == last) chk("step_count", step_count, (rel == last) ? n : 0);
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("extra_output", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("out_ch", out_ch, e.ch);
          chk("out_x", $signed(out_x), e.x);
          chk("out_y", $signed(out_y), e.y);
          last_x[out_ch] = out_x;
          last_y[out_ch] = out_y;
          nout++;
        end
      end
      if (poke && rel == 4) begin
        start = 1'b1; nsteps = 16'd7; mode = ~md; k = $urandom;
        ld_valid = 1'b1; ld_ch = 2'd0;
        ld_x = $urandom; ld_y = $urandom; ld_vx = $urandom; ld_vy = $urandom;
      end
      @(negedge clk);
      if (poke && rel == 4) begin
        start = 1'b0; ld_valid = 1'b0;
      end
    end
    chk("missing_outputs", expq.size(), 0);
    expq.delete();
    $display("run n=%0d mode=%0d k=%08h poke=%0d outputs=%0d errors=%0d",
             n, md, kk, poke, nout, errors);
  endtask

  function automatic logic [W-1:0] rnd_word();
    int sel;
    sel = $urandom_range(0, 4);
    case (sel)
      0: return $urandom;
      1: return W'($urandom_range(0, 32'h0007_FFFF)) - 32'h0004_0000;
      2: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      3: return 32'h0;
      default: return W'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; ld_valid = 1'b0;
    nsteps = '0; k = '0; ld_ch = '0;
    ld_x = '0; ld_y = '0; ld_vx = '0; ld_vy = '0;
    model_clear();

    vt[0] = '{1'b1, 0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0001_0000, 1'b1, 32'h0000_FF00, 32'h0};
    vt[1] = '{1'b1, 0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0001_0000, 1'b0, 32'h0001_0000, 32'h0};
    vt[2] = '{1'b0, 0, 32'h0,         32'h0, 32'h0, 32'h0, 32'h0001_0000, 1'b0, 32'h0000_FF00, 32'h0};
    vt[3] = '{1'b1, 1, 32'h7FFF_0000, 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h7FFF_FFFF, 32'h0};
    vt[4] = '{1'b1, 1, 32'h8001_0000, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 32'h8000_0000, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_step_count", step_count, 0);
    rst = 1'b0;
    $display("reset check errors=%0d", errors);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      if (vt[i].do_load) load(vt[i].ch, vt[i].x, vt[i].y, vt[i].vx, vt[i].vy);
      run(1, vt[i].md, vt[i].kk, 1'b0);
      chk("vec_x", last_x[vt[i].ch], vt[i].ex);
      chk("vec_y", last_y[vt[i].ch], vt[i].ey);
      $display("vector %0d ch=%0d out_x=%08h want %08h", i, vt[i].ch, last_x[vt[i].ch], vt[i].ex);
    end

    // Multi-step stream with a stray start/load while busy
    for (int j = 0; j < NCH; j++) load(j, rnd_word(), rnd_word(), rnd_word(), rnd_word());
    run(3, 1'b1, 32'h0000_8000, 1'b1);

    // Zero-step run
    run(0, 1'b0, 32'h0001_0000, 1'b0);

    // Reset mid-run
    @(negedge clk);
    start = 1'b1; nsteps = 16'd3; mode = 1'b0; k = 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_step_count", step_count, 0);
    chk("midrst_out_x", out_x, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
      chk("midrst_idle", busy, 0);
    end
    $display("mid-run reset errors=%0d", errors);
    model_clear();
    run(1, 1'b1, 32'h0002_0000, 1'b0);

    // Randomized runs against the model
    for (int it = 0; it < 10; it++) begin
      for (int j = 0; j < NCH; j++) begin
        if ($urandom_range(0, 3) != 0) load(j, rnd_word(), rnd_word(), rnd_word(), rnd_word());
      end
      run($urandom_range(1, 4), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h0003_0000)),
          1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
